// File: rtl/param_proc_pkg.sv
// Shared encodings for the parametrised bus processor: opcodes, sequencer steps and ALU operations.
package param_proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_MVNZ = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  typedef enum logic [2:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_XOR,
    ALU_SLL
  } alu_op_t;

  // Maps an instruction opcode onto the operation the ALU performs in step T2.
  function automatic alu_op_t alu_op_for(input logic [2:0] opcode);
    case (opcode)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      OP_SLL:  return ALU_SLL;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/param_proc_alu.sv
// Combinational ALU: A operand from the accumulator, B operand from the shared bus.
module param_proc_alu
  import param_proc_pkg::*;
#(
  parameter int REG_WIDTH = 16
) (
  input  alu_op_t              op,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic [REG_WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a + ~b + REG_WIDTH'(1);
      ALU_AND: y = a & b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = {a[REG_WIDTH-2:0], 1'b0};
      default: y = a;
    endcase
  end

endmodule

// File: rtl/param_proc_core.sv
// Multi-cycle bus processor: NUM_REGS registers, A/G accumulator pair and a zero flag around
// one shared one-hot bus, sequenced by a T0..T3 step counter under a run/done handshake.
module param_proc_core
  import param_proc_pkg::*;
#(
  parameter int REG_WIDTH     = 16,
  parameter int NUM_REGS      = 8,
  parameter int COUNTER_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [REG_WIDTH-1:0] din,
  output logic [REG_WIDTH-1:0] bus,
  output logic                 done,
  output logic                 busy,
  output logic                 zero
);

  localparam int SEL_W       = $clog2(NUM_REGS);
  localparam int INSTR_WIDTH = 3 + 2 * SEL_W;

  logic [COUNTER_WIDTH-1:0] step_q;
  step_t                    step, step_d;

  logic [INSTR_WIDTH-1:0] ir;
  logic [2:0]             opcode;
  logic [SEL_W-1:0]       rx, ry;

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [REG_WIDTH-1:0] a_q, g_q, alu_y;
  logic                 z_q;

  logic [NUM_REGS-1:0] sel_reg;
  logic                sel_din, sel_g;
  logic                rx_in, a_in, g_in;
  alu_op_t             alu_op;

  assign step   = step_t'(step_q);
  assign opcode = ir[INSTR_WIDTH-1 -: 3];
  assign rx     = ir[2*SEL_W-1 -: SEL_W];
  assign ry     = ir[SEL_W-1:0];
  assign busy   = (step != T0);
  assign zero   = z_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values;
  // combinational blocks use blocking (=) and assign every output a default first, so no
  // path through them leaves a value held (which would infer a latch).
  always_ff @(posedge clk) begin
    if (rst) step_q <= COUNTER_WIDTH'(T0);
    else     step_q <= COUNTER_WIDTH'(step_d);
  end

  always_comb begin
    step_d  = step;
    sel_reg = '0;
    sel_din = 1'b0;
    sel_g   = 1'b0;
    rx_in   = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    done    = 1'b0;
    alu_op  = ALU_PASS;
    case (step)
      T0: if (run) step_d = T1;
      T1: begin
        case (opcode)
          OP_MV: begin
            sel_reg[ry] = 1'b1;
            rx_in       = 1'b1;
            done        = 1'b1;
            step_d      = T0;
          end
          OP_MVI: begin
            sel_din = 1'b1;
            rx_in   = 1'b1;
            done    = 1'b1;
            step_d  = T0;
          end
          OP_MVNZ: begin
            // A set Z turns the move into a no-op that still completes the handshake.
            if (!z_q) begin
              sel_reg[ry] = 1'b1;
              rx_in       = 1'b1;
            end
            done   = 1'b1;
            step_d = T0;
          end
          default: begin
            sel_reg[rx] = 1'b1;
            a_in        = 1'b1;
            step_d      = T2;
          end
        endcase
      end
      T2: begin
        if (opcode != OP_SLL) sel_reg[ry] = 1'b1;
        g_in   = 1'b1;
        alu_op = alu_op_for(opcode);
        step_d = T3;
      end
      T3: begin
        sel_g  = 1'b1;
        rx_in  = 1'b1;
        done   = 1'b1;
        step_d = T0;
      end
      default: step_d = T0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir  <= '0;
      a_q <= '0;
      g_q <= '0;
      z_q <= 1'b0;
    end else begin
      if (step == T0 && run) ir <= din[INSTR_WIDTH-1:0];
      if (a_in) a_q <= bus;
      if (g_in) begin
        g_q <= alu_y;
        z_q <= (alu_y == '0);
      end
    end
  end

  param_proc_alu #(.REG_WIDTH(REG_WIDTH)) u_alu (
    .op (alu_op),
    .a  (a_q),
    .b  (bus),
    .y  (alu_y)
  );

  // NOTE: the register file is built from flops, not a RAM macro, so it can and does
  // clear on reset; a RAM-backed array would have to drop this reset branch.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [REG_WIDTH-1:0] q;
    always_ff @(posedge clk) begin
      if (rst)                             q <= '0;
      else if (rx_in && rx == SEL_W'(i))   q <= bus;
    end
    assign regs[i] = q;
  end

  always_comb begin
    bus = (din & {REG_WIDTH{sel_din}}) | (g_q & {REG_WIDTH{sel_g}});
    for (int i = 0; i < NUM_REGS; i++) bus |= regs[i] & {REG_WIDTH{sel_reg[i]}};
  end

  a_bus_onehot : assert property (@(posedge clk) disable iff (rst)
                                  $onehot0({sel_reg, sel_din, sel_g}))
    else $error("param_proc_core: more than one bus source selected");

endmodule
